// File: rtl/qpsk_mapper_if.sv
// qpsk_mapper_if
//   Bundles the symbol input stream and the I/Q sample output stream of the
//   QPSK mapper so that the driver and the mapper share one port.
//
//   Input stream  (driven by master): valid_i, data_i[1:0], diff_en
//   Output stream (driven by slave) : valid_o, i_o[W-1:0], q_o[W-1:0],
//                                     sop_o, eop_o, sym_cnt_o[15:0], err_o
interface qpsk_mapper_if #(
  parameter int W = 8
);
  logic                valid_i;
  logic [1:0]          data_i;
  logic                diff_en;
  logic                valid_o;
  logic signed [W-1:0] i_o;
  logic signed [W-1:0] q_o;
  logic                sop_o;
  logic                eop_o;
  logic [15:0]         sym_cnt_o;
  logic                err_o;

  modport master (
    output valid_i, data_i, diff_en,
    input  valid_o, i_o, q_o, sop_o, eop_o, sym_cnt_o, err_o
  );

  modport slave (
    input  valid_i, data_i, diff_en,
    output valid_o, i_o, q_o, sop_o, eop_o, sym_cnt_o, err_o
  );
endinterface

// File: rtl/qpsk_mapper.sv
// qpsk_mapper
//   Maps Gray-coded dibits onto a QPSK constellation, optionally with
//   differential phase encoding, and frames each burst of symbols with a
//   fixed-length tail of zero samples.
//
//   Parameters: W        output sample width (signed)
//               AMP      constellation magnitude, 0 < AMP <= 2^(W-1)-1
//               TAIL_LEN zero samples appended per burst, 1..15
//   Ports:      CLK      clock, rising edge
//               RST      asynchronous active-low reset
//               bus      qpsk_mapper_if slave: symbol stream in, samples out,
//                        burst framing (sop_o/eop_o), last burst symbol
//                        count (sym_cnt_o) and sticky truncation flag (err_o)
//   All outputs are registered; a symbol on data_i appears one cycle later.
module qpsk_mapper #(
  parameter int W        = 8,
  parameter int AMP      = 90,
  parameter int TAIL_LEN = 4
) (
  input  logic          CLK,
  input  logic          RST,
  qpsk_mapper_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TAIL   = 2'd2
  } state_t;

  localparam logic signed [W-1:0] AMP_P     = W'(AMP);
  localparam logic signed [W-1:0] AMP_N     = -AMP_P;
  localparam logic [3:0]          TAIL_LAST = 4'(TAIL_LEN - 1);

  // Gray dibit to phase increment in quarter turns.
  function automatic logic [1:0] gray_inc(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      2'b11:   r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          p_q, p_d;
  logic                diff_q, diff_d;
  logic [3:0]          tail_q, tail_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         sym_cnt_q, sym_cnt_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic signed [W-1:0] i_q, i_d;
  logic signed [W-1:0] q_q, q_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;

  logic [1:0] inc;
  logic [1:0] p_sum;
  logic [1:0] phase;
  logic       start;
  logic       emit_sym;

  // data_i only enters the datapath when qualified, so an undriven bus
  // while valid_i is low cannot leak into the accumulator or outputs.
  assign inc   = bus.valid_i ? gray_inc(bus.data_i) : 2'd0;
  assign p_sum = p_q + inc;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    diff_d    = diff_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    sym_cnt_d = sym_cnt_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    i_d       = '0;
    q_d       = '0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    phase     = 2'd0;
    start     = 1'b0;
    emit_sym  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          start = 1'b1;
        end
      end

      ACTIVE: begin
        valid_d = 1'b1;
        if (bus.valid_i) begin
          emit_sym = 1'b1;
          if (diff_q) begin
            phase = p_sum;
            p_d   = p_sum;
          end else begin
            phase = inc;
          end
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (TAIL_LEN == 1) begin
          // The single tail sample is also the last one.
          eop_d     = 1'b1;
          sym_cnt_d = cnt_q;
          state_d   = IDLE;
        end else begin
          // tail_q counts tail samples already emitted.
          tail_d  = 4'd1;
          state_d = TAIL;
        end
      end

      TAIL: begin
        if (bus.valid_i) begin
          // New data cuts the tail short: the old burst never gets eop_o.
          err_d = 1'b1;
          start = 1'b1;
        end else begin
          valid_d = 1'b1;
          if (tail_q == TAIL_LAST) begin
            eop_d     = 1'b1;
            sym_cnt_d = cnt_q;
            tail_d    = 4'd0;
            state_d   = IDLE;
          end else begin
            tail_d = tail_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Burst start: accumulator restarts from zero, so its new value and
    // the emitted phase are both just the first increment.
    if (start) begin
      state_d  = ACTIVE;
      diff_d   = bus.diff_en;
      p_d      = inc;
      tail_d   = 4'd0;
      cnt_d    = 16'd1;
      valid_d  = 1'b1;
      sop_d    = 1'b1;
      phase    = inc;
      emit_sym = 1'b1;
    end

    if (emit_sym) begin
      i_d = (phase == 2'd0 || phase == 2'd3) ? AMP_P : AMP_N;
      q_d = (phase == 2'd0 || phase == 2'd1) ? AMP_P : AMP_N;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      p_q       <= 2'd0;
      diff_q    <= 1'b0;
      tail_q    <= 4'd0;
      cnt_q     <= 16'd0;
      sym_cnt_q <= 16'd0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      i_q       <= '0;
      q_q       <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      diff_q    <= diff_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      sym_cnt_q <= sym_cnt_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      i_q       <= i_d;
      q_q       <= q_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.i_o       = i_q;
  assign bus.q_o       = q_q;
  assign bus.sop_o     = sop_q;
  assign bus.eop_o     = eop_q;
  assign bus.sym_cnt_o = sym_cnt_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_qpsk_mapper.sv
// tb_qpsk_mapper
//   Self-checking bench for qpsk_mapper. Two instances share clock and
//   reset: one with the default tail length, one with a single-sample tail.
//   Observed outputs are packed as {valid, sop, eop, i, q, sym_cnt, err}.
module tb_qpsk_mapper;

  localparam int W  = 8;
  localparam int TL = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  qpsk_mapper_if #(.W(W)) bus ();
  qpsk_mapper_if #(.W(W)) bus1 ();

  qpsk_mapper #(.W(W), .AMP(90), .TAIL_LEN(TL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  qpsk_mapper #(.W(W), .AMP(90), .TAIL_LEN(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1)
  );

  wire logic [35:0] obs  = {bus.valid_o, bus.sop_o, bus.eop_o, bus.i_o, bus.q_o,
                            bus.sym_cnt_o, bus.err_o};
  wire logic [35:0] obs1 = {bus1.valid_o, bus1.sop_o, bus1.eop_o, bus1.i_o, bus1.q_o,
                            bus1.sym_cnt_o, bus1.err_o};

  int n_cmp = 0;
  int n_bad = 0;
  int exp_last_cnt = 0;

  // Reference tables: phase -> (I,Q), dibit value -> Gray increment.
  int tab_i[4] = '{90, -90, -90, 90};
  int tab_q[4] = '{90, 90, -90, -90};
  int gray[4]  = '{0, 1, 3, 2};

  function automatic logic [35:0] ev(input logic v, input logic sop, input logic eop,
                                     input int i, input int q, input int cnt,
                                     input logic err);
    return {v, sop, eop, 8'(i), 8'(q), 16'(cnt), err};
  endfunction

  // Apply one cycle of input at a negedge; return at the next negedge,
  // where the registered response to that input is visible.
  task automatic cyc(input logic v, input logic [1:0] d, input logic de);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.diff_en = de;
    @(negedge CLK);
  endtask

  task automatic cyc1(input logic v, input logic [1:0] d, input logic de);
    bus1.valid_i = v;
    bus1.data_i  = d;
    bus1.diff_en = de;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [35:0] e;
    @(negedge CLK);
    @(negedge CLK);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_dut: got %h want %h", obs, e); end
    n_cmp++;
    if (obs1 !== e) begin n_bad++; $display("FAIL reset_dut1: got %h want %h", obs1, e); end
    RST = 1'b1;
    cyc(1'b0, 2'b11, 1'b1);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL idle_after_reset: got %h want %h", obs, e); end
    $display("test_reset done");
  endtask

  task automatic test_vectors();
    logic [1:0]  d[4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
    int          ei[4] = '{90, -90, -90, 90};
    int          eq[4] = '{90, 90, -90, -90};
    logic [35:0] e;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, d[k], 1'b0);
      e = ev(1, k == 0, 0, ei[k], eq[k], 0, 0);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL vec_sym%0d: got %h want %h", k, obs, e); end
    end
    for (int k = 0; k < TL; k++) begin
      cyc(1'b0, 2'b00, 1'b0);
      e = ev(1, 0, k == TL - 1, 0, 0, (k == TL - 1) ? 4 : 0, 0);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL vec_tail%0d: got %h want %h", k, obs, e); end
    end
    cyc(1'b0, 2'b00, 1'b0);
    e = ev(0, 0, 0, 0, 0, 4, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL vec_idle: got %h want %h", obs, e); end
    exp_last_cnt = 4;
    $display("test_vectors done");
  endtask

  task automatic test_diff();
    int          ph[5] = '{1, 2, 3, 0, 1};
    logic [35:0] e;
    for (int k = 0; k < 5; k++) begin
      // diff_en only matters on the first symbol of the burst
      cyc(1'b1, 2'b01, k == 0);
      e = ev(1, k == 0, 0, tab_i[ph[k]], tab_q[ph[k]], exp_last_cnt, 0);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL diff_sym%0d: got %h want %h", k, obs, e); end
    end
    for (int k = 0; k < TL; k++) begin
      cyc(1'b0, 2'b01, 1'b0);
    end
    e = ev(1, 0, 1, 0, 0, 5, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL diff_eop: got %h want %h", obs, e); end
    exp_last_cnt = 5;
    $display("test_diff done");
  endtask

  task automatic test_tail1();
    logic [35:0] e;
    cyc1(1'b1, 2'b00, 1'b0);
    e = ev(1, 1, 0, 90, 90, 0, 0);
    n_cmp++;
    if (obs1 !== e) begin n_bad++; $display("FAIL tail1_sym: got %h want %h", obs1, e); end
    cyc1(1'b0, 2'b00, 1'b0);
    e = ev(1, 0, 1, 0, 0, 1, 0);
    n_cmp++;
    if (obs1 !== e) begin n_bad++; $display("FAIL tail1_eop: got %h want %h", obs1, e); end
    cyc1(1'b0, 2'b00, 1'b0);
    e = ev(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (obs1 !== e) begin n_bad++; $display("FAIL tail1_idle: got %h want %h", obs1, e); end
    $display("test_tail1 done");
  endtask

  // Random bursts: expected stream built per burst from the mapping rules,
  // then played cycle by cycle.
  task automatic test_random();
    logic        sv[$];
    logic [1:0]  sd[$];
    logic        sde[$];
    logic [35:0] eq[$];
    logic [35:0] e;
    int          len, acc, ph, inc, gap;
    logic        dif;
    logic [1:0]  d;
    for (int b = 0; b < 8; b++) begin
      dif = 1'($urandom % 2);
      len = $urandom_range(1, 12);
      acc = 0;
      for (int j = 0; j < len; j++) begin
        d   = 2'($urandom % 4);
        inc = gray[d];
        acc = (acc + inc) % 4;
        ph  = dif ? acc : inc;
        sv.push_back(1'b1);
        sd.push_back(d);
        sde.push_back(j == 0 ? dif : 1'($urandom % 2));
        eq.push_back(ev(1, j == 0, 0, tab_i[ph], tab_q[ph], exp_last_cnt, 0));
      end
      for (int k = 0; k < TL; k++) begin
        if (k == TL - 1) exp_last_cnt = len;
        sv.push_back(1'b0);
        sd.push_back(2'($urandom % 4));
        sde.push_back(1'($urandom % 2));
        eq.push_back(ev(1, 0, k == TL - 1, 0, 0, exp_last_cnt, 0));
      end
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) begin
        sv.push_back(1'b0);
        sd.push_back(2'($urandom % 4));
        sde.push_back(1'($urandom % 2));
        eq.push_back(ev(0, 0, 0, 0, 0, exp_last_cnt, 0));
      end
    end
    for (int n = 0; n < sv.size(); n++) begin
      cyc(sv[n], sd[n], sde[n]);
      e = eq[n];
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL random_cyc%0d: got %h want %h", n, obs, e); end
    end
    $display("test_random done: %0d cycles", sv.size());
  endtask

  task automatic test_truncate();
    logic [35:0] e;
    int          l = exp_last_cnt;
    cyc(1'b1, 2'b00, 1'b0);
    e = ev(1, 1, 0, 90, 90, l, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL trunc_sym0: got %h want %h", obs, e); end
    cyc(1'b1, 2'b01, 1'b0);
    e = ev(1, 0, 0, -90, 90, l, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL trunc_sym1: got %h want %h", obs, e); end
    cyc(1'b0, 2'b00, 1'b0);
    e = ev(1, 0, 0, 0, 0, l, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL trunc_tail0: got %h want %h", obs, e); end
    cyc(1'b1, 2'b11, 1'b0);
    e = ev(1, 1, 0, -90, -90, l, 1);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL trunc_restart: got %h want %h", obs, e); end
    for (int k = 0; k < TL; k++) begin
      cyc(1'b0, 2'b00, 1'b0);
      e = ev(1, 0, k == TL - 1, 0, 0, (k == TL - 1) ? 1 : l, 1);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL trunc_tail%0d: got %h want %h", k, obs, e); end
    end
    exp_last_cnt = 1;
    $display("test_truncate done");
  endtask

  task automatic test_reset_mid();
    logic [35:0] e;
    logic [1:0]  d;
    int          ph;
    cyc(1'b1, 2'b10, 1'b1);
    cyc(1'b1, 2'b01, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL rst_async: got %h want %h", obs, e); end
    @(negedge CLK);
    bus.valid_i = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL rst_held: got %h want %h", obs, e); end
    RST = 1'b1;
    cyc(1'b0, 2'b00, 1'b0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL rst_idle: got %h want %h", obs, e); end
    for (int k = 0; k < 3; k++) begin
      d  = 2'($urandom % 4);
      ph = gray[d];
      cyc(1'b1, d, 1'b0);
      e = ev(1, k == 0, 0, tab_i[ph], tab_q[ph], 0, 0);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL rst_sym%0d: got %h want %h", k, obs, e); end
    end
    for (int k = 0; k < TL; k++) begin
      cyc(1'b0, 2'b00, 1'b0);
    end
    e = ev(1, 0, 1, 0, 0, 3, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL rst_eop: got %h want %h", obs, e); end
    exp_last_cnt = 3;
    $display("test_reset_mid done");
  endtask

  task automatic test_saturation();
    logic [35:0] e;
    for (int k = 0; k < 70000; k++) begin
      cyc(1'b1, 2'b00, 1'b0);
    end
    e = ev(1, 0, 0, 90, 90, exp_last_cnt, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL sat_last_sym: got %h want %h", obs, e); end
    for (int k = 0; k < TL; k++) begin
      cyc(1'b0, 2'b00, 1'b0);
    end
    e = ev(1, 0, 1, 0, 0, 16'hFFFF, 0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL sat_eop: got %h want %h", obs, e); end
    $display("test_saturation done");
  endtask

  initial begin
    bus.valid_i  = 1'b0;
    bus.data_i   = 2'b00;
    bus.diff_en  = 1'b0;
    bus1.valid_i = 1'b0;
    bus1.data_i  = 2'b00;
    bus1.diff_en = 1'b0;
    test_reset();
    test_vectors();
    test_diff();
    test_tail1();
    test_random();
    test_truncate();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
